// File: rtl/ushift_pkg.sv
// ---------------------------------------------------------------------------
// ushift_pkg
// Shared definitions for the universal shift register: opcode width, opcode
// constants and the control state encoding.
// Build option: USHIFT_ABORT_EN (see ushift_reg_if.sv / ushift_reg.sv).
// ---------------------------------------------------------------------------
package ushift_pkg;

   localparam int OP_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_NOP  = 3'b000;
   localparam op_t OP_LOAD = 3'b001;
   localparam op_t OP_SHR  = 3'b010;
   localparam op_t OP_SHL  = 3'b011;
   localparam op_t OP_SAR  = 3'b100;
   localparam op_t OP_ROR  = 3'b101;
   localparam op_t OP_ROL  = 3'b110;
   localparam op_t OP_CLR  = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/ushift_reg_if.sv
// ---------------------------------------------------------------------------
// ushift_reg_if
// Request/response bundle of the universal shift register.
//   master : drives start, op, amt, data_in, ser_in (and abort when
//            USHIFT_ABORT_EN is defined); observes data_out, b_out,
//            b_valid, busy, done.
//   slave  : the register side (ushift_reg).
// Build option: USHIFT_ABORT_EN adds the abort request line.
// ---------------------------------------------------------------------------
interface ushift_reg_if
   import ushift_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W + 1)
) ();

   logic             start;
   op_t              op;
   logic [CNT_W-1:0] amt;
   logic [W-1:0]     data_in;
   logic             ser_in;
`ifdef USHIFT_ABORT_EN
   logic             abort;
`endif
   logic [W-1:0]     data_out;
   logic             b_out;
   logic             b_valid;
   logic             busy;
   logic             done;

`ifdef USHIFT_ABORT_EN
   modport master (
      output start, op, amt, data_in, ser_in, abort,
      input  data_out, b_out, b_valid, busy, done
   );
   modport slave (
      input  start, op, amt, data_in, ser_in, abort,
      output data_out, b_out, b_valid, busy, done
   );
`else
   modport master (
      output start, op, amt, data_in, ser_in,
      input  data_out, b_out, b_valid, busy, done
   );
   modport slave (
      input  start, op, amt, data_in, ser_in,
      output data_out, b_out, b_valid, busy, done
   );
`endif

endinterface

// File: rtl/ushift_step.sv
// ---------------------------------------------------------------------------
// ushift_step
// Combinational single-bit step of the universal shift register.
//   op       : latched operation (only the shift/rotate codes move data)
//   value    : current register contents
//   ser_in   : fill bit for SHR (into MSB) and SHL (into LSB)
//   next     : register contents after one step
//   out_bit  : bit leaving the register on this step
// Non-shift codes pass the value through with out_bit = 0.
// ---------------------------------------------------------------------------
module ushift_step
   import ushift_pkg::*;
#(
   parameter int W = 8
) (
   input  op_t          op,
   input  logic [W-1:0] value,
   input  logic         ser_in,
   output logic [W-1:0] next,
   output logic         out_bit
);

   always_comb begin
      next    = value;
      out_bit = 1'b0;
      case (op)
         OP_SHR: begin
            next    = {ser_in, value[W-1:1]};
            out_bit = value[0];
         end
         OP_SHL: begin
            next    = {value[W-2:0], ser_in};
            out_bit = value[W-1];
         end
         OP_SAR: begin
            next    = {value[W-1], value[W-1:1]};
            out_bit = value[0];
         end
         OP_ROR: begin
            next    = {value[0], value[W-1:1]};
            out_bit = value[0];
         end
         OP_ROL: begin
            next    = {value[W-2:0], value[W-1]};
            out_bit = value[W-1];
         end
         default: begin
            next    = value;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ushift_reg.sv
// ---------------------------------------------------------------------------
// ushift_reg
// Parametrised universal shift register with multi-cycle shift-by-N
// sequencing and a start/busy/done handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, aborts any shift in progress
//   bus  : ushift_reg_if.slave (start/op/amt/data_in/ser_in in,
//          data_out/b_out/b_valid/busy/done out)
// Build option: USHIFT_ABORT_EN adds bus.abort, which ends a running shift
// on the next edge without taking a step.
// ---------------------------------------------------------------------------
module ushift_reg
   import ushift_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic        clk,
   input  logic        rst,
   ushift_reg_if.slave bus
);

   localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_t              op_q, op_d;
   logic [W-1:0]     data_q, data_d;
   logic             b_q, b_d;
   logic             bv_q, bv_d;
   logic             done_q, done_d;

   logic [W-1:0]     step_next;
   logic             step_bit;
   logic             abort_req;

   // Shift counts above W are meaningless for a W-bit register; clamping to
   // W gives a full rotation or a full ser_in flush.
   function automatic logic [CNT_W-1:0] sat_amt(input logic [CNT_W-1:0] a);
      return (a > W_CNT) ? W_CNT : a;
   endfunction

`ifdef USHIFT_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   ushift_step #(.W(W)) u_step (
      .op      (op_q),
      .value   (data_q),
      .ser_in  (bus.ser_in),
      .next    (step_next),
      .out_bit (step_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         data_q  <= '0;
         b_q     <= 1'b0;
         bv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         data_q  <= data_d;
         b_q     <= b_d;
         bv_q    <= bv_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      data_d  = data_q;
      b_d     = b_q;
      bv_d    = bv_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d = bus.op;
               case (bus.op)
                  OP_NOP: begin
                     done_d = 1'b1;
                  end
                  OP_LOAD: begin
                     data_d = bus.data_in;
                     b_d    = 1'b0;
                     bv_d   = 1'b0;
                     done_d = 1'b1;
                  end
                  OP_CLR: begin
                     data_d = '0;
                     b_d    = 1'b0;
                     bv_d   = 1'b0;
                     done_d = 1'b1;
                  end
                  default: begin
                     // A zero-length shift completes like a NOP.
                     if (bus.amt == '0) begin
                        done_d = 1'b1;
                     end else begin
                        cnt_d   = sat_amt(bus.amt);
                        state_d = ST_SHIFT;
                     end
                  end
               endcase
            end
         end

         ST_SHIFT: begin
            if (abort_req) begin
               // Abort wins over the pending step: data and bit-out hold.
               cnt_d   = '0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               data_d = step_next;
               b_d    = step_bit;
               bv_d   = 1'b1;
               cnt_d  = cnt_q - ONE;
               if (cnt_q == ONE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.data_out = data_q;
   assign bus.b_out    = b_q;
   assign bus.b_valid  = bv_q;
   assign bus.busy     = (state_q == ST_SHIFT);
   assign bus.done     = done_q;

endmodule

// File: doc/ushift_reg.md
Name: ushift_reg

Overview:
- Parametrised universal shift register; successor to the single-bit right-shift/load register.
- Adds shift-left, arithmetic shift, rotate and clear operations, a serial input, and multi-cycle shift-by-N sequencing with a start/busy/done handshake.
- Used as a datapath building block: serial shifting in multiply/divide sequencers, and serialisers.

Parameters:
- W, 8, data width in bits (W >= 2).
- CNT_W, $clog2(W+1), width of the shift-amount field and of the internal down-counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation code; latched when start is accepted.
- amt  input  CNT_W  shift count; latched when start is accepted.
- data_in  input  W  load value, used by LOAD.
- ser_in  input  1  serial fill bit for SHR/SHL, sampled on every shift edge.
- data_out  output  W  register contents.
- b_out  output  1  last bit shifted or rotated out.
- b_valid  output  1  b_out holds a bit from a shift.
- busy  output  1  a multi-cycle shift is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1): data_out=0, b_out=0, b_valid=0, busy=0, done=0, counter=0, latched op=NOP. Reset takes effect immediately, including mid-operation, and aborts any shift in progress.
- Opcodes:
  - 000 NOP
  - 001 LOAD
  - 010 SHR (MSB filled with ser_in)
  - 011 SHL (LSB filled with ser_in)
  - 100 SAR (MSB replicated)
  - 101 ROR
  - 110 ROL
  - 111 CLR
- Single-cycle ops (NOP, LOAD, CLR, and any shift with amt=0): executed on the accepting edge. done=1 for the following cycle and busy stays 0.
  - LOAD: data_out<=data_in, b_out<=0, b_valid<=0.
  - CLR: data_out<=0, b_out<=0, b_valid<=0.
  - NOP and amt=0: data_out, b_out and b_valid unchanged.
- Multi-cycle shifts (op 010..110, amt>0):
  - Accepting edge (edge 0): op latched, counter<=min(amt,W), busy<=1. Data is unchanged.
  - Edges 1..N: one 1-bit step per edge, counter decremented.
  - On edge N: busy<=0 and done<=1 (one cycle).
  - Total latency from start to done is N+1 edges.
- Per step: b_out<=the bit leaving the register (SHR/SAR/ROR: bit 0; SHL/ROL: bit W-1), b_valid<=1.
- amt greater than W saturates to W. For rotates this is a full rotation; for SHR/SHL it is a full flush of W ser_in bits.
- start while busy=1 is ignored: no latch, no queuing. start is accepted again on the edge after done is raised.
- done is never high together with busy.

Optional Feature:
- Macro: USHIFT_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 while busy=1: on that edge no step occurs, busy<=0, done<=1, and data_out, b_out, b_valid keep their current values.
  - abort has priority over a pending step.
  - abort while idle is ignored.
- Undefined: no abort port; a shift always runs to completion or until rst.

Decomposition:
- Package ushift_pkg holds:
  - opcode localparams (OP_NOP, OP_LOAD, OP_SHR, OP_SHL, OP_SAR, OP_ROR, OP_ROL, OP_CLR);
  - the opcode width constant (3).
- Sub-module ushift_step: combinational single-bit step.
  - Inputs: op, value, ser_in.
  - Outputs: next value, out bit.
  - Instantiated once in ushift_reg, which holds the counter, handshake and registers.

Test Plan (W=8):
- Reset: rst=1 mid-run -> data_out=0x00, b_out=0, b_valid=0, busy=0, done=0 immediately, before the next clock edge.
- LOAD 0xAA: start -> next cycle data_out=0xAA, done=1 for one cycle, busy never 1, b_valid=0.
- SHR amt=3, ser_in=0, from 0xAA:
  - data_out steps 0x55, 0x2A, 0x15;
  - b_out 0, 1, 0; busy high for 3 cycles;
  - done pulse after the third step.
- SAR amt=2 from 0x80 -> 0xC0 then 0xE0, b_out=0, b_valid=1. Then SHL amt=1, ser_in=1 -> 0xC1, b_out=1.
- ROL amt=12 (saturates to 8) from 0x96 -> 8 steps, final data_out=0x96, final b_out=0. start pulsed during busy has no effect.
- With USHIFT_ABORT_EN: ROR amt=5 from 0x01, abort asserted after 2 steps -> data_out=0x40, busy=0, done=1 for one cycle, b_out=0.
